// File: rtl/zero_opt_pkg.sv
// Shared definitions for the zero-optimisation replacement stage.
//   - default datapath sizes
//   - FSM state encoding (LOAD = candidate banks being filled, READY = vectors flowing)
//   - helper for the per-lane select width
package zero_opt_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 16;
  localparam int unsigned DEF_TN        = 16;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_t;

  // Select codes span 0 (pass-through) plus one code per flat candidate.
  function automatic int unsigned sel_width(input int unsigned d, input int unsigned tn);
    return $clog2(d * tn + 1);
  endfunction

endpackage

// File: rtl/zero_opt_lane_mux.sv
// Single-lane (NUM_CAND+1):1 mux: sel 0 passes the input lane, sel k picks flat
// candidate k-1, any larger sel yields 0 and raises err_c.
// Ports:
//   cand   - all candidates, flat index 0 in LSBs
//   in_val - this lane's input value
//   sel    - this lane's select code
//   val_c  - substituted value (combinational)
//   err_c  - select out of range (combinational)
module zero_opt_lane_mux #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned NUM_CAND  = 48,
  parameter int unsigned SEL_WIDTH = 6
) (
  input  logic [NUM_CAND*BIT_WIDTH-1:0] cand,
  input  logic [BIT_WIDTH-1:0]          in_val,
  input  logic [SEL_WIDTH-1:0]          sel,
  output logic [BIT_WIDTH-1:0]          val_c,
  output logic                          err_c
);

  always_comb begin
    val_c = '0;
    err_c = (sel > SEL_WIDTH'(NUM_CAND));
    if (sel == '0) begin
      val_c = in_val;
    end
    for (int unsigned k = 0; k < NUM_CAND; k++) begin
      if (sel == SEL_WIDTH'(k + 1)) begin
        val_c = cand[k*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/zero_opt_repl_stage.sv
// Zero-optimisation replacement stage in front of NFU-1.
// Fills D banks of Tn candidates from a stream, then substitutes input lanes from
// those banks under per-lane select and registers the result with valid/ready.
// Ports:
//   clk, rst_n                            - clock, async active-low reset
//   i_cand_valid/o_cand_ready/i_cand_data - candidate bank stream (auto bank counter)
//   i_cand_flush                          - restart candidate loading at bank 0
//   i_in_valid/o_in_ready/i_in_data       - input vector stream
//   i_in_sel, i_in_last                   - per-lane select, end-of-window marker
//   o_out_valid/i_out_ready/o_out_data    - substituted output stream
//   o_zero_mask, o_nz_count               - zero lanes / nonzero lane count of output
//   o_sel_err                             - sticky out-of-range select flag
module zero_opt_repl_stage
  import zero_opt_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned Tn        = DEF_TN,
  parameter int unsigned D         = 3,
  parameter int unsigned SEL_WIDTH = sel_width(D, Tn),
  parameter int unsigned CNT_WIDTH = $clog2(Tn + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cand_valid,
  output logic                    o_cand_ready,
  input  logic [BIT_WIDTH*Tn-1:0] i_cand_data,
  input  logic                    i_cand_flush,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [BIT_WIDTH*Tn-1:0] i_in_data,
  input  logic [SEL_WIDTH*Tn-1:0] i_in_sel,
  input  logic                    i_in_last,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [BIT_WIDTH*Tn-1:0] o_out_data,
  output logic [Tn-1:0]           o_zero_mask,
  output logic [CNT_WIDTH-1:0]    o_nz_count,
  output logic                    o_sel_err
);

  localparam int unsigned BANK_W   = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned BANK_BITS = BIT_WIDTH * Tn;

  state_t                   state_q, state_d;
  logic [BANK_W-1:0]        bank_cnt_q, bank_cnt_d;
  logic [D*BANK_BITS-1:0]   cand_q;
  logic [BANK_BITS-1:0]     lane_val;
  logic [Tn-1:0]            lane_err;
  logic [Tn-1:0]            zero_mask_c;
  logic [CNT_WIDTH-1:0]     nz_count_c;
  logic                     cand_write;
  logic                     in_fire;

  // Handshake qualifiers; a flush blocks both streams for that cycle.
  assign o_cand_ready = (state_q == LOAD);
  assign o_in_ready   = (state_q == READY) && !i_cand_flush && (!o_out_valid || i_out_ready);
  assign cand_write   = o_cand_ready && i_cand_valid && !i_cand_flush;
  assign in_fire      = i_in_valid && o_in_ready;

  // State and bank counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      bank_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bank_cnt_q <= bank_cnt_d;
    end
  end

  // Next-state: fill banks in order, serve vectors until the window's last one.
  always_comb begin
    state_d    = state_q;
    bank_cnt_d = bank_cnt_q;
    if (i_cand_flush) begin
      state_d    = LOAD;
      bank_cnt_d = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (cand_write) begin
            if (bank_cnt_q == BANK_W'(D - 1)) begin
              bank_cnt_d = '0;
              state_d    = READY;
            end else begin
              bank_cnt_d = bank_cnt_q + BANK_W'(1);
            end
          end
        end
        READY: begin
          if (in_fire && i_in_last) begin
            state_d = LOAD;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // Candidate bank storage; contents survive flushes and window ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= '0;
    end else begin
      for (int unsigned b = 0; b < D; b++) begin
        if (cand_write && (bank_cnt_q == BANK_W'(b))) begin
          cand_q[b*BANK_BITS +: BANK_BITS] <= i_cand_data;
        end
      end
    end
  end

  // Per-lane substitution.
  for (genvar i = 0; i < Tn; i++) begin : g_lane
    zero_opt_lane_mux #(
      .BIT_WIDTH (BIT_WIDTH),
      .NUM_CAND  (D * Tn),
      .SEL_WIDTH (SEL_WIDTH)
    ) u_mux (
      .cand   (cand_q),
      .in_val (i_in_data[i*BIT_WIDTH +: BIT_WIDTH]),
      .sel    (i_in_sel[i*SEL_WIDTH +: SEL_WIDTH]),
      .val_c  (lane_val[i*BIT_WIDTH +: BIT_WIDTH]),
      .err_c  (lane_err[i])
    );
  end

  // Zero mask and nonzero popcount of the substituted vector.
  always_comb begin
    zero_mask_c = '0;
    nz_count_c  = '0;
    for (int unsigned i = 0; i < Tn; i++) begin
      if (lane_val[i*BIT_WIDTH +: BIT_WIDTH] == '0) begin
        zero_mask_c[i] = 1'b1;
      end else begin
        nz_count_c = nz_count_c + CNT_WIDTH'(1);
      end
    end
  end

  // Output register: load on accept, drop valid when drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_zero_mask <= '0;
      o_nz_count  <= '0;
      o_sel_err   <= 1'b0;
    end else begin
      if (in_fire) begin
        o_out_valid <= 1'b1;
        o_out_data  <= lane_val;
        o_zero_mask <= zero_mask_c;
        o_nz_count  <= nz_count_c;
        if (|lane_err) begin
          o_sel_err <= 1'b1;
        end
      end else if (i_out_ready) begin
        o_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/zero_opt_repl_stage.md
Name: zero_opt_repl_stage

Overview:
- Parametrised zero-optimisation front end for the NFU pipeline; sits between NBin/candidate SRAM reads and NFU-1.
- Holds D banks of Tn replacement candidates, loaded by a valid/ready stream with an auto-incrementing bank counter. There is no external bank-select bus.
- Substitutes per-lane input values from those banks under sel control and registers the result with a valid/ready output. Also emits a zero mask and a nonzero-lane count.
- Generalises the fixed D3/D5 variants to any D and adds flow control, per-window reload and error flagging.

Parameters:
- BIT_WIDTH, 16, bits per neuron/candidate value
- Tn, 16, lanes per input vector
- D, 3, number of candidate banks (>=1)
- SEL_WIDTH, $clog2(D*Tn+1), per-lane select width (derived; do not override)
- CNT_WIDTH, $clog2(Tn+1), width of nonzero-lane count (derived)

Ports:
- clk  in  1  main clock
- rst_n  in  1  asynchronous active-low reset
- i_cand_valid  in  1  candidate bank word valid
- o_cand_ready  out  1  stage can accept a candidate bank
- i_cand_data  in  BIT_WIDTH*Tn  one candidate bank (lane 0 in LSBs)
- i_cand_flush  in  1  discard load progress, restart at bank 0
- i_in_valid  in  1  input vector valid
- o_in_ready  out  1  input vector accepted this cycle when high with valid
- i_in_data  in  BIT_WIDTH*Tn  NBin vector
- i_in_sel  in  SEL_WIDTH*Tn  per-lane select (lane 0 in LSBs)
- i_in_last  in  1  last vector of window; candidates must be reloaded after it
- o_out_valid  out  1  output vector valid
- i_out_ready  in  1  NFU-1 side ready
- o_out_data  out  BIT_WIDTH*Tn  substituted vector
- o_zero_mask  out  Tn  bit i set when o_out_data lane i == 0
- o_nz_count  out  CNT_WIDTH  number of nonzero lanes in o_out_data
- o_sel_err  out  1  sticky: an accepted vector had an out-of-range sel

Behaviour:
- FSM states LOAD and READY. Reset state is LOAD with bank_cnt = 0.
- Reset values: o_out_valid 0, o_out_data 0, o_zero_mask 0, o_nz_count 0, o_sel_err 0. Candidate banks reset to 0.
- LOAD state:
  - o_cand_ready = 1 and o_in_ready = 0.
  - A cand handshake writes bank[bank_cnt] and increments bank_cnt.
  - A write with bank_cnt == D-1 sets bank_cnt to 0 and moves to READY next cycle. With D = 1, the first write moves to READY.
- READY state:
  - o_cand_ready = 0.
  - o_in_ready = !i_cand_flush && (!o_out_valid || i_out_ready).
  - An input handshake with i_in_last = 1 returns to LOAD. Bank contents are kept until overwritten.
- i_cand_flush, in either state: next state LOAD, bank_cnt = 0, bank contents unchanged.
  - In LOAD, a flush takes priority over a same-cycle cand write; that write is dropped even though o_cand_ready was high.
  - The output register is unaffected and keeps draining.
- Substitution is combinational on accepted data, per lane i:
  - sel = 0 selects i_in_data lane i.
  - sel = k, 1 <= k <= D*Tn, selects flat candidate k-1, which is bank (k-1)/Tn, lane (k-1)%Tn.
  - sel > D*Tn drives the lane to 0 and sets o_sel_err (sticky until reset).
- Output register:
  - Loads on input handshake: o_out_data, o_zero_mask, o_nz_count, o_out_valid = 1.
  - Latency is 1 cycle from input handshake to o_out_valid.
  - Clears o_out_valid on i_out_ready without a new handshake.
  - Holds all outputs stable while o_out_valid && !i_out_ready.
  - Back-to-back throughput is 1 vector/cycle when i_out_ready is held high.
- A vector accepted on the same cycle as a bank write cannot happen (states are exclusive).
- Reset mid-operation: everything returns to its reset values immediately (asynchronous). Any in-flight vector is lost.

Decomposition:
- Package zero_opt_pkg: BIT_WIDTH/Tn defaults, FSM state encoding (LOAD=1'b0, READY=1'b1), helper function for SEL_WIDTH.
- One sub-module zero_opt_lane_mux: a single-lane (D*Tn+1):1 mux with out-of-range detect, instantiated Tn times by generate.
- The popcount is inline.

Test Plan:
- D=3, Tn=16: load banks with lane values 0x1000+16b+l. Next vector uses sel lane0=1, lane1=48, lane2=0 with in_data lane2=0x0042. Expect out lane0=0x1000, lane1=0x102F, lane2=0x0042, 1 cycle after handshake.
- In LOAD, drive i_in_valid=1 → o_in_ready stays 0 and no output. After the third bank write, o_in_ready rises the next cycle.
- Hold i_out_ready=0 for 4 cycles with a vector pending → o_out_data stable, o_in_ready=0. Release → next vector accepted the same cycle.
- After 2 of 3 bank writes, assert i_cand_flush → bank_cnt restarts; 3 further writes are needed before READY. In READY, flush with i_in_valid=1 → vector not accepted, state LOAD.
- sel=49 (D*Tn+1) on lane 5 → out lane 5 = 0, o_zero_mask[5] = 1, o_sel_err = 1 and stays 1 over later valid vectors.
- in_data all zero with sel=0 → o_zero_mask = 0xFFFF, o_nz_count = 0. Vector with i_in_last=1 → o_cand_ready = 1 next cycle.
